// File: rtl/detector_sentido_pkg.sv
// detector_sentido_pkg: state encoding and counter width helper for the crossing detector
package detector_sentido_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    E1     = 3'd1,
    E2     = 3'd2,
    E3     = 3'd3,
    X1     = 3'd4,
    X2     = 3'd5,
    X3     = 3'd6,
    ESPERA = 3'd7
  } state_t;
  function automatic int cnt_w(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/detector_sentido_antirrebote.sv
// antirrebote: 2-flop synchronizer plus debouncer for one raw sensor line
module antirrebote
  import detector_sentido_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb
);
  localparam int CW = cnt_w(DEB_CYCLES);
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync <= '0;
      cnt  <= '0;
      deb  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == deb) cnt <= '0;
      else if (cnt == CW'(DEB_CYCLES - 1)) begin
        deb <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/detector_sentido.sv
// detector_sentido: turns two debounced photo-barrier sensors into entry/exit pulses,
// rejecting aborted, reversed or stuck crossings.
module detector_sentido
  import detector_sentido_pkg::*;
#(
  parameter int DEB_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic sa,
  input  logic sb,
  input  logic lleno,
  output logic z1,
  output logic z2,
  output logic err,
  output logic barrera
);
  localparam int TW = cnt_w(TIMEOUT_CYCLES);
  logic          a, b, act, to;
  logic [1:0]    ab;
  logic [TW-1:0] tcnt;
  state_t        state, nxt, n;
  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_a (.clk(clk), .reset(reset), .raw(sa), .deb(a));
  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_b (.clk(clk), .reset(reset), .raw(sb), .deb(b));
  assign ab = {a, b};
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = ab == 2'b10 ? E1 : ab == 2'b01 ? X1 : ab == 2'b11 ? ESPERA : IDLE;
      E1:      nxt = ab == 2'b11 ? E2 : ab == 2'b00 ? IDLE : ab == 2'b01 ? ESPERA : E1;
      E2:      nxt = ab == 2'b01 ? E3 : ab == 2'b10 ? E1 : ab == 2'b00 ? ESPERA : E2;
      E3:      nxt = ab == 2'b00 ? IDLE : ab == 2'b11 ? E2 : ab == 2'b10 ? ESPERA : E3;
      X1:      nxt = ab == 2'b11 ? X2 : ab == 2'b00 ? IDLE : ab == 2'b10 ? ESPERA : X1;
      X2:      nxt = ab == 2'b10 ? X3 : ab == 2'b01 ? X1 : ab == 2'b00 ? ESPERA : X2;
      X3:      nxt = ab == 2'b00 ? IDLE : ab == 2'b11 ? X2 : ab == 2'b01 ? ESPERA : X3;
      ESPERA:  nxt = ab == 2'b00 ? IDLE : ESPERA;
      default: nxt = IDLE;
    endcase
  end
  // a crossing stuck in one state for too long is abandoned
  assign act = state != IDLE && state != ESPERA;
  assign to  = act && nxt == state && tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign n   = to ? ESPERA : nxt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= IDLE;
      tcnt    <= '0;
      z1      <= 1'b0;
      z2      <= 1'b0;
      err     <= 1'b0;
      barrera <= 1'b0;
    end else begin
      state   <= n;
      tcnt    <= (act && n == state) ? tcnt + TW'(1) : '0;
      z1      <= state == E3 && n == IDLE && !lleno;
      z2      <= state == X3 && n == IDLE;
      err     <= (n == ESPERA && state != ESPERA) || (state == E3 && n == IDLE && lleno);
      barrera <= !lleno && n != ESPERA;
    end
endmodule

// File: tb/tb_detector_sentido.sv
// tb_detector_sentido: directed checks of debounce, crossing decode, full lot, timeout and reset
module tb_detector_sentido;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sa = 1'b0, sb = 1'b0, lleno = 1'b0;
  logic z1, z2, err, barrera;
  logic z1t, z2t, errt, barrerat;
  int n_chk = 0, n_fail = 0;
  int n_z1 = 0, n_z2 = 0, n_err = 0, n_bar = 0, n_both = 0, n_errt = 0;

  detector_sentido #(.DEB_CYCLES(4), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .reset(reset), .sa(sa), .sb(sb), .lleno(lleno),
    .z1(z1), .z2(z2), .err(err), .barrera(barrera));
  detector_sentido #(.DEB_CYCLES(4), .TIMEOUT_CYCLES(16)) dut_t (
    .clk(clk), .reset(reset), .sa(sa), .sb(sb), .lleno(lleno),
    .z1(z1t), .z2(z2t), .err(errt), .barrera(barrerat));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (z1) n_z1++;
    if (z2) n_z2++;
    if (err) n_err++;
    if (barrera) n_bar++;
    if (z1 && z2) n_both++;
    if (errt) n_errt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_z1 = 0; n_z2 = 0; n_err = 0; n_bar = 0; n_errt = 0;
  endtask

  task automatic hold(input logic a_, input logic b_, input int cyc);
    sa = a_;
    sb = b_;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    #2;
    check("rst_z1", z1, 0);
    check("rst_z2", z2, 0);
    check("rst_err", err, 0);
    check("rst_barrera", barrera, 0);
    check("rst_state", dut.state, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("barrera_after_release", barrera, 1);
    hold(0, 0, 10);

    // clean entry with exact pulse latency
    clr();
    hold(1, 0, 20);
    hold(1, 1, 20);
    hold(0, 1, 20);
    sa = 0; sb = 0;
    repeat (6) @(posedge clk);
    #1 check("entry_z1_early", z1, 0);
    @(posedge clk); #1 check("entry_z1_pulse", z1, 1);
    @(posedge clk); #1 check("entry_z1_end", z1, 0);
    hold(0, 0, 10);
    check("entry_z1_count", n_z1, 1);
    check("entry_z2_count", n_z2, 0);
    check("entry_err_count", n_err, 0);

    // clean exit followed by a backed-out entry
    clr();
    hold(0, 1, 20);
    hold(1, 1, 20);
    hold(1, 0, 20);
    hold(0, 0, 20);
    check("exit_z2_count", n_z2, 1);
    check("exit_z1_count", n_z1, 0);
    check("exit_err_count", n_err, 0);
    clr();
    hold(1, 0, 20);
    check("backout_state_e1", dut.state, 1);
    hold(0, 0, 20);
    check("backout_pulses", n_z1 + n_z2, 0);
    check("backout_err", n_err, 0);
    check("backout_state", dut.state, 0);

    // chatter on sa never passes the debouncer
    for (int i = 0; i < 10; i++) begin
      sa = ~sa;
      @(posedge clk); #1;
      check("chatter_a", dut.a, 0);
    end
    hold(0, 0, 10);
    check("chatter_state", dut.state, 0);

    // full lot: entry completes without z1, err once, barrier closed
    lleno = 1'b1;
    @(posedge clk); #1;
    clr();
    hold(1, 0, 20);
    hold(1, 1, 20);
    hold(0, 1, 20);
    hold(0, 0, 20);
    check("full_z1_count", n_z1, 0);
    check("full_err_count", n_err, 1);
    check("full_barrera_high", n_bar, 0);
    check("full_state", dut.state, 0);
    lleno = 1'b0;
    hold(0, 0, 20);
    check("barrera_reopen", barrera, 1);

    // stuck sensor on the 16-cycle timeout instance
    check("to_start_idle", dut_t.state, 0);
    clr();
    sa = 1'b1;
    k = 0;
    while (dut_t.state != 3'd1 && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    check("to_enter_e1", dut_t.state, 1);
    k = 0;
    while (!errt && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("to_cycles", k, 16);
    check("to_state_espera", dut_t.state, 7);
    check("to_barrera", barrerat, 0);
    hold(1, 0, 10);
    check("to_still_espera", dut_t.state, 7);
    check("to_err_once", n_errt, 1);
    hold(0, 0, 20);
    check("to_back_idle", dut_t.state, 0);
    check("to_barrera_back", barrerat, 1);

    // reset in the middle of a crossing
    clr();
    hold(1, 0, 20);
    hold(1, 1, 20);
    check("mid_state_e2", dut.state, 2);
    reset = 1'b0;
    sa = 0; sb = 0;
    #1;
    check("mid_state_rst", dut.state, 0);
    check("mid_barrera_rst", barrera, 0);
    check("mid_outs_rst", {z1, z2, err}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    hold(0, 0, 30);
    check("mid_pulses", n_z1 + n_z2 + n_err, 0);
    check("mid_state_idle", dut.state, 0);
    check("never_z1_z2", n_both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
